// File: rtl/e_mdu_issue.sv
// E-stage issue controller for the multiply/divide unit.
// Generates Start, stalls dependent instructions and muxes HI/LO.
module e_mdu_issue #(
  parameter int TIMEOUT = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  EOp,
  input  logic [1:0]  ERead,
  input  logic        EFlush,
  input  logic        Busy,
  input  logic [31:0] HI,
  input  logic [31:0] LO,
  output logic [2:0]  MDUOpOut,
  output logic        Start,
  output logic        Stall,
  output logic [31:0] ReadData,
  output logic        Timeout,
  output logic [15:0] StallCnt,
  output logic [15:0] IssueCnt
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ERR
  } state_t;

  localparam logic [3:0] WLIM = 4'(TIMEOUT - 1);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       mdop;
  logic       mtop;
  logic       rd_hi;
  logic       rd_lo;
  logic       uses;
  logic       in_wait;
  logic       in_err;
  logic       issue_ok;

  assign mdop    = (EOp >= 3'd1) && (EOp <= 3'd4);
  assign mtop    = (EOp == 3'd5) || (EOp == 3'd6);
  assign rd_hi   = (ERead == 2'b01);
  assign rd_lo   = (ERead == 2'b10);
  assign uses    = mdop | mtop | rd_hi | rd_lo;
  assign in_wait = (state == WAIT);
  assign in_err  = (state == ERR);

  // ERR stalls every MDU user so a lost result can't slip through.
  assign Stall = uses & ~EFlush
               & ((in_wait & Busy) | in_err);

  assign issue_ok = ~Stall & ~EFlush & ~in_err;
  assign Start    = mdop & issue_ok;
  assign MDUOpOut = (issue_ok & (mdop | mtop)) ? EOp : 3'd0;

  always_comb begin
    ReadData = 32'd0;
    unique case (1'b1)
      rd_hi:   ReadData = HI;
      rd_lo:   ReadData = LO;
      default: ReadData = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      Timeout  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            state    <= WAIT;
            wait_cnt <= 4'd0;
          end
        end
        WAIT: begin
          if (Start) begin
            wait_cnt <= 4'd0;
          end else if (!Busy) begin
            state <= IDLE;
          end else if (wait_cnt == WLIM) begin
            state   <= ERR;
            Timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ERR: begin
          state <= ERR;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      StallCnt <= 16'd0;
      IssueCnt <= 16'd0;
    end else begin
      if (Stall && (StallCnt != 16'hFFFF))
        StallCnt <= StallCnt + 16'd1;
      if (Start)
        IssueCnt <= IssueCnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_e_mdu_issue.sv
// Scoreboard bench for e_mdu_issue.
// Busy/HI/LO are driven directly to play the MDU.
module tb_e_mdu_issue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  EOp = 3'd0;
  logic [1:0]  ERead = 2'd0;
  logic        EFlush = 1'b0;
  logic        Busy = 1'b0;
  logic [31:0] HI = 32'd0;
  logic [31:0] LO = 32'd0;
  logic [2:0]  MDUOpOut;
  logic        Start;
  logic        Stall;
  logic [31:0] ReadData;
  logic        Timeout;
  logic [15:0] StallCnt;
  logic [15:0] IssueCnt;

  logic [31:0] nhi = 32'd0;
  logic [31:0] nlo = 32'd0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic        st;
    logic        sl;
    logic [2:0]  op;
    logic [31:0] rd;
  } exp_t;

  exp_t q[$];

  e_mdu_issue #(.TIMEOUT(12)) dut (
    .clk(clk),
    .reset(reset),
    .EOp(EOp),
    .ERead(ERead),
    .EFlush(EFlush),
    .Busy(Busy),
    .HI(HI),
    .LO(LO),
    .MDUOpOut(MDUOpOut),
    .Start(Start),
    .Stall(Stall),
    .ReadData(ReadData),
    .Timeout(Timeout),
    .StallCnt(StallCnt),
    .IssueCnt(IssueCnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.tag, ".start"}, 32'(Start), 32'(e.st));
      chk({e.tag, ".stall"}, 32'(Stall), 32'(e.sl));
      chk({e.tag, ".op"}, 32'(MDUOpOut), 32'(e.op));
      chk({e.tag, ".rdata"}, ReadData, e.rd);
    end
  end

  task automatic step(string tag, logic [2:0] e,
                      logic [1:0] r, logic f, logic b,
                      logic est, logic esl,
                      logic [2:0] eop);
    exp_t x;
    @(posedge clk);
    #1;
    EOp = e;
    ERead = r;
    EFlush = f;
    Busy = b;
    HI = nhi;
    LO = nlo;
    x.tag = tag;
    x.st = est;
    x.sl = esl;
    x.op = eop;
    x.rd = (r == 2'b01) ? nhi :
           (r == 2'b10) ? nlo : 32'd0;
    q.push_back(x);
  endtask

  task automatic rep(string tag, int n, logic [2:0] e,
                     logic [1:0] r, logic f, logic b,
                     logic est, logic esl,
                     logic [2:0] eop);
    for (int i = 0; i < n; i++)
      step(tag, e, r, f, b, est, esl, eop);
  endtask

  task automatic cnt_chk(string tag, logic to,
                         logic [15:0] sc,
                         logic [15:0] ic);
    @(negedge clk);
    #1;
    chk({tag, ".timeout"}, 32'(Timeout), 32'(to));
    chk({tag, ".stallcnt"}, 32'(StallCnt), 32'(sc));
    chk({tag, ".issuecnt"}, 32'(IssueCnt), 32'(ic));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst.start", 32'(Start), 32'd0);
    chk("rst.stall", 32'(Stall), 32'd0);
    chk("rst.op", 32'(MDUOpOut), 32'd0);
    chk("rst.timeout", 32'(Timeout), 32'd0);
    chk("rst.stallcnt", 32'(StallCnt), 32'd0);
    chk("rst.issuecnt", 32'(IssueCnt), 32'd0);
    reset = 1'b1;

    // first issue, idle follower
    step("t1.mult", 3'd1, 2'd0, 0, 0, 1, 0, 3'd1);
    step("t1.nop", 3'd0, 2'd0, 0, 1, 0, 0, 3'd0);
    step("t1.done", 3'd0, 2'd0, 0, 0, 0, 0, 3'd0);
    cnt_chk("t1", 0, 16'd0, 16'd1);

    // mult then dependent mflo
    step("t2.mult", 3'd1, 2'd0, 0, 0, 1, 0, 3'd1);
    rep("t2.mflo_w", 5, 3'd0, 2'b10, 0, 1, 0, 1, 3'd0);
    nlo = 32'h0000_000C;
    step("t2.mflo_r", 3'd0, 2'b10, 0, 0, 0, 0, 3'd0);
    cnt_chk("t2", 0, 16'd5, 16'd2);

    // div then mthi behind it
    step("t3.div", 3'd3, 2'd0, 0, 0, 1, 0, 3'd3);
    rep("t3.mthi_w", 10, 3'd5, 2'd0, 0, 1, 0, 1, 3'd0);
    step("t3.mthi", 3'd5, 2'd0, 0, 0, 0, 0, 3'd5);
    cnt_chk("t3", 0, 16'd15, 16'd3);

    // divu issues as Busy falls; watchdog restarts
    nhi = 32'hDEAD_0001;
    step("t4.mult", 3'd1, 2'd0, 0, 0, 1, 0, 3'd1);
    step("t4.divu_w", 3'd4, 2'd0, 0, 1, 0, 1, 3'd0);
    step("t4.divu", 3'd4, 2'd0, 0, 0, 1, 0, 3'd4);
    rep("t4.mfhi_w", 11, 3'd0, 2'b01, 0, 1, 0, 1, 3'd0);
    step("t4.mfhi", 3'd0, 2'b01, 0, 0, 0, 0, 3'd0);
    cnt_chk("t4", 0, 16'd27, 16'd5);

    // flush in IDLE and during WAIT, non-users in WAIT
    step("t5.fl_idle", 3'd2, 2'd0, 1, 0, 0, 0, 3'd0);
    step("t5.mult", 3'd1, 2'd0, 0, 0, 1, 0, 3'd1);
    cnt_chk("t5a", 0, 16'd27, 16'd5);
    step("t5.fl_wait", 3'd2, 2'd0, 1, 1, 0, 0, 3'd0);
    step("t5.fl_mflo", 3'd0, 2'b10, 1, 1, 0, 0, 3'd0);
    step("t5.nop", 3'd0, 2'd0, 0, 1, 0, 0, 3'd0);
    step("t5.rd11", 3'd0, 2'b11, 0, 1, 0, 0, 3'd0);
    step("t5.rsvd", 3'd7, 2'd0, 0, 1, 0, 0, 3'd0);
    step("t5.done", 3'd0, 2'd0, 0, 0, 0, 0, 3'd0);
    cnt_chk("t5b", 0, 16'd27, 16'd6);

    // watchdog trip, ERR stalls users until reset
    step("t6.mult", 3'd1, 2'd0, 0, 0, 1, 0, 3'd1);
    rep("t6.busy", 11, 3'd0, 2'd0, 0, 1, 0, 0, 3'd0);
    cnt_chk("t6a", 0, 16'd27, 16'd7);
    step("t6.busy12", 3'd0, 2'd0, 0, 1, 0, 0, 3'd0);
    step("t6.err_mfhi", 3'd0, 2'b01, 0, 0, 0, 1, 3'd0);
    cnt_chk("t6b", 1, 16'd27, 16'd7);
    step("t6.err_mult", 3'd1, 2'd0, 0, 0, 0, 1, 3'd0);
    rep("t6.err_hold", 2, 3'd0, 2'b01, 0, 0, 0, 1, 3'd0);
    cnt_chk("t6c", 1, 16'd30, 16'd7);

    // asynchronous reset mid-cycle
    #2;
    reset = 1'b0;
    #1;
    chk("t7.rst_stall", 32'(Stall), 32'd0);
    chk("t7.rst_timeout", 32'(Timeout), 32'd0);
    chk("t7.rst_stallcnt", 32'(StallCnt), 32'd0);
    chk("t7.rst_issuecnt", 32'(IssueCnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step("t7.mult", 3'd1, 2'd0, 0, 0, 1, 0, 3'd1);
    step("t7.mfhi_w", 3'd0, 2'b01, 0, 1, 0, 1, 3'd0);
    cnt_chk("t7", 0, 16'd0, 16'd1);

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/e_mdu_issue.md
# e_mdu_issue

Execute-stage issue controller between the D/E pipeline register and the multiply/divide unit. Forwards MDU operations from the instruction in E, generates the Start pulse and stalls the pipeline while the MDU is busy, muxes HI/LO for mfhi/mflo, and keeps a watchdog plus performance counters. It consumes the MDU's Busy/HI/LO outputs and drives the MDU's MDUOp/Start inputs.

## Interface
- TIMEOUT, 12: WAIT cycles with Busy still high before the watchdog trips.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- EOp  in  3  MDU op of the instruction in E: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- ERead  in  2  01 = mfhi, 10 = mflo, 00/11 = no read.
- EFlush  in  1  instruction in E is being killed this cycle.
- Busy  in  1  MDU busy flag.
- HI, LO  in  32 each  MDU result registers.
- MDUOpOut  out  3  op presented to the MDU.
- Start  out  1  start pulse to the MDU.
- Stall  out  1  to the hazard unit: freeze F/D/E and bubble M.
- ReadData  out  32  HI or LO value for mfhi/mflo.
- Timeout  out  1  sticky watchdog flag.
- StallCnt  out  16  saturating count of stall cycles.
- IssueCnt  out  16  wrapping count of Start pulses.

## Operation
- The instruction uses the MDU (`uses`) when EOp is in 1..6 or ERead is 01/10.
- `mdop` means EOp is in 1..4.
- States:
  - IDLE: the MDU is free.
  - WAIT: an operation has been issued and completion is being tracked.
  - ERR: watchdog tripped; absorbing until reset.
- Stall = uses && !EFlush && ((state==WAIT && Busy) || state==ERR).
- Start = mdop && !EFlush && !Stall && state!=ERR.
- MDUOpOut = EOp when !Stall && !EFlush && state!=ERR and EOp is 1..6; otherwise 0. Ops 5/6 (mthi/mtlo) pass through without Start.
- ReadData:
  - HI when ERead==01.
  - LO when ERead==10.
  - 0 otherwise.
  - Combinational from the live inputs, so it is valid in the cycle Stall drops.
- State transitions:
  - IDLE: Start -> WAIT, wait_cnt <= 0.
  - WAIT:
    - Start (Busy low, new mdop) -> stay in WAIT, wait_cnt <= 0.
    - else !Busy -> IDLE.
    - else if wait_cnt == TIMEOUT-1 -> ERR, Timeout <= 1.
    - else wait_cnt <= wait_cnt+1.
  - ERR: held until reset. Stall is 1 for every MDU-using instruction, so the hazard is visible rather than silently corrupting HI/LO.
- Counters:
  - StallCnt increments each Stall cycle and saturates at 0xFFFF.
  - IssueCnt increments on each Start and wraps 0xFFFF -> 0.
  - wait_cnt is 4 bits.

## Timing
- Reset (asserted low, asynchronous):
  - state IDLE, wait_cnt 0, Timeout 0, StallCnt 0, IssueCnt 0.
  - Start 0, Stall 0, MDUOpOut 0; ReadData follows its combinational rule.
- Start is combinational and is sampled by the MDU at the same edge that moves this block to WAIT. Busy is therefore high in the first WAIT cycle.
- Back-to-back: mult then mflo.
  - The mflo stalls from the cycle after the mult's Start until the first cycle Busy is low.
  - In that cycle Stall=0 and ReadData equals the new LO.
- mult (5 busy cycles) gives 5 stall cycles to a dependent follower; div gives 10.
- Simultaneous events:
  - Busy falling with a new mdop in E: Start fires, the state stays WAIT, and IssueCnt increments.
  - EFlush overrides everything: no Start, MDUOpOut 0, Stall 0 for that instruction.
- Non-MDU instructions (uses=0) never stall, even during WAIT.
- Reset mid-WAIT returns to IDLE immediately. The MDU is reset by the same reset.

## Test plan
- Reset low, then release; EOp=1 for one cycle -> Start=1 and MDUOpOut=1 that cycle, IssueCnt=1. Next cycle state WAIT. An instruction with EOp=0 and ERead=0 -> Stall=0.
- mult, then mflo held in E; Busy high 5 cycles -> Stall=1 for exactly 5 cycles. In the first Busy-low cycle Stall=0 and ReadData=LO (e.g. 0x0000000C for 3*4). StallCnt=5.
- div issued; mthi (EOp=5) in E during Busy -> MDUOpOut=0 and Stall=1 until Busy drops, then MDUOpOut=5 with Start=0.
- Busy falls while divu is in E -> Start=1 that cycle, state stays WAIT, IssueCnt increments by 1, wait_cnt restarts.
- EFlush=1 with EOp=2 in IDLE -> Start=0, MDUOpOut=0, IssueCnt unchanged. Same with EFlush during WAIT -> Stall=0.
- Busy stuck high 12 WAIT cycles -> Timeout=1 and ERR. A later mfhi gives Stall=1 permanently. Pulse reset low -> Timeout=0, IDLE, counters 0.
